// File: rtl/mips_pkg.sv
// Shared MIPS-core constants: instruction width, NOP/HALT words and the
// program-loader state encoding.
package mips_pkg;

  localparam int               MIPS_INSTR_W   = 32;
  localparam logic [31:0]      MIPS_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0]      MIPS_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_byte_assembler.sv
// Packs an MSB-first byte stream into NBITS-wide words; word_valid_o marks
// the byte that completes a word, with word_o already including that byte.
module instr_byte_assembler
  import mips_pkg::*;
#(
  parameter int NBITS = MIPS_INSTR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  output logic             word_valid_o,
  output logic [NBITS-1:0] word_o
);

  localparam int NBYTES = NBITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NBYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-9:0] asm_q;
  logic [NBITS-1:0] asm_next;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the older bytes are stored; the current byte completes the word.
  assign asm_next = {asm_q, byte_i};

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      asm_q <= asm_next[NBITS-9:0];
    end
  end

  assign word_valid_o = en_i && (cnt_q == LAST_C);
  assign word_o       = asm_next;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: byte-stream program loader plus a
// stallable one-cycle fetch port. Define INSTR_MEM_PARITY_EN for per-word parity.
module instr_mem_loadable
  import mips_pkg::*;
#(
  parameter int               NBITS     = MIPS_INSTR_W,
  parameter int               DEPTH     = 256,
  parameter logic [NBITS-1:0] HALT_WORD = MIPS_HALT_WORD,
  parameter logic [NBITS-1:0] NOP_WORD  = MIPS_NOP_WORD,
  localparam int              ADDR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_prog_words,
  output logic              o_ready,
  input  logic              i_fetch_en,
  input  logic [NBITS-1:0]  i_PC,
  output logic [NBITS-1:0]  o_Instruction,
  output logic              o_instr_valid,
`ifdef INSTR_MEM_PARITY_EN
  output logic              o_parity_err,
`endif
  output logic              o_addr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  load_state_e      state_q, state_d;
  logic [ADDR_W:0]  ptr_q, ptr_d, words_q, words_d, ptr_inc;
  logic             done_q, done_d;
  logic             byte_en, word_valid, last_word;
  logic [NBITS-1:0] asm_word;
  logic [NBITS-1:0] mem [DEPTH];

  // Bytes only count while loading, and a start in the same cycle discards them.
  assign byte_en = (state_q == ST_LOAD) && i_load_valid && !i_load_start;

  instr_byte_assembler #(.NBITS(NBITS)) u_asm (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .clr_i        (i_load_start),
    .en_i         (byte_en),
    .byte_i       (i_load_byte),
    .word_valid_o (word_valid),
    .word_o       (asm_word)
  );

  assign ptr_inc   = ptr_q + (ADDR_W + 1)'(1);
  assign last_word = word_valid && ((asm_word == HALT_WORD) || (ptr_inc == DEPTH_C));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    done_d  = 1'b0;
    if (i_load_start) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      words_d = '0;
    end else if (word_valid) begin
      ptr_d   = ptr_inc;
      words_d = ptr_inc;
      if (last_word) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    o_ready      = (state_q == ST_RUN);
    o_load_done  = done_q;
    o_prog_words = words_q;
  end

  always_ff @(posedge i_clk) begin
    if (word_valid) begin
      mem[ptr_q[ADDR_W-1:0]] <= asm_word;
    end
  end

  logic [ADDR_W-1:0] fidx;
  logic              run_now, aligned, in_range;
  logic [NBITS-1:0]  instr_q, instr_d;
  logic              ivld_q, ivld_d, aerr_q, aerr_d;

  assign fidx     = i_PC[ADDR_W+1:2];
  assign aligned  = (i_PC[1:0] == 2'b00);
  assign in_range = ((i_PC >> (ADDR_W + 2)) == '0) && ({1'b0, fidx} < words_q);
  // A start in the fetch cycle already invalidates the program being read.
  assign run_now  = (state_q == ST_RUN) && !i_load_start;

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_q, perr_d;

  function automatic logic even_par(input logic [NBITS-1:0] w);
    return ^w;
  endfunction

  always_ff @(posedge i_clk) begin
    if (word_valid) begin
      par_mem[ptr_q[ADDR_W-1:0]] <= even_par(asm_word);
    end
  end

  assign o_parity_err = perr_q;
`endif

  always_comb begin
    instr_d = NOP_WORD;
    ivld_d  = 1'b0;
    aerr_d  = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (run_now) begin
      if (aligned && in_range) begin
        instr_d = mem[fidx];
        ivld_d  = 1'b1;
`ifdef INSTR_MEM_PARITY_EN
        perr_d  = (even_par(mem[fidx]) != par_mem[fidx]);
        ivld_d  = !perr_d;
`endif
      end else begin
        aerr_d = 1'b1;
      end
    end
  end

  // Fetch stage: outputs update only while fetch is enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_q <= NOP_WORD;
      ivld_q  <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (i_fetch_en) begin
      instr_q <= instr_d;
      ivld_q  <= ivld_d;
      aerr_q  <= aerr_d;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_Instruction = instr_q;
  assign o_instr_valid = ivld_q;
  assign o_addr_err    = aerr_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench: two DUTs (DEPTH 256 and 4) share one random stimulus
// stream; a program-level model predicts each cycle's outputs.
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, valid, fe;
  logic [7:0]  byte_in;
  logic [31:0] pc;

  logic        done0, rdy0, iv0, ae0, done1, rdy1, iv1, ae1;
  logic [8:0]  pw0;
  logic [2:0]  pw1;
  logic [31:0] ins0, ins1;
`ifdef INSTR_MEM_PARITY_EN
  logic        pe0, pe1;
`endif

  instr_mem_loadable #(.DEPTH(256)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(start), .i_load_valid(valid),
    .i_load_byte(byte_in), .o_load_done(done0), .o_prog_words(pw0), .o_ready(rdy0),
    .i_fetch_en(fe), .i_PC(pc), .o_Instruction(ins0), .o_instr_valid(iv0),
`ifdef INSTR_MEM_PARITY_EN
    .o_parity_err(pe0),
`endif
    .o_addr_err(ae0)
  );

  instr_mem_loadable #(.DEPTH(4)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(start), .i_load_valid(valid),
    .i_load_byte(byte_in), .o_load_done(done1), .o_prog_words(pw1), .o_ready(rdy1),
    .i_fetch_en(fe), .i_PC(pc), .o_Instruction(ins1), .o_instr_valid(iv1),
`ifdef INSTR_MEM_PARITY_EN
    .o_parity_err(pe1),
`endif
    .o_addr_err(ae1)
  );

  typedef struct {
    logic [31:0] instr;
    bit          iv, ae, done, rdy;
    int          words;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  // Reference model: a program is a list of words; fetch returns list[pc/4].
  bit          m_load [2], m_run [2], m_done [2], m_iv [2], m_ae [2];
  int          m_words [2], m_nb [2];
  logic [31:0] m_asm [2], m_ins [2];
  logic [31:0] m_prog [2][256];

  task automatic model(input int d, output exp_t e);
    longint widx;
    int     depth;
    depth = (d == 0) ? 256 : 4;
    widx  = longint'(pc >> 2);
    if (!rst_n) begin
      m_load[d] = 0; m_run[d] = 0; m_done[d] = 0; m_words[d] = 0; m_nb[d] = 0;
      m_ins[d] = NOP; m_iv[d] = 0; m_ae[d] = 0;
    end else begin
      if (fe) begin
        if (m_run[d] && pc % 4 == 0 && widx < longint'(m_words[d])) begin
          m_ins[d] = m_prog[d][int'(widx)]; m_iv[d] = 1; m_ae[d] = 0;
        end else begin
          m_ins[d] = NOP; m_iv[d] = 0; m_ae[d] = m_run[d];
        end
      end
      m_done[d] = 0;
      if (start) begin
        m_load[d] = 1; m_run[d] = 0; m_words[d] = 0; m_nb[d] = 0;
      end else if (m_load[d] && valid) begin
        m_asm[d] = (m_asm[d] << 8) | {24'd0, byte_in};
        m_nb[d]++;
        if (m_nb[d] == 4) begin
          m_nb[d] = 0;
          m_prog[d][m_words[d]] = m_asm[d];
          m_words[d]++;
          if (m_asm[d] == HALT || m_words[d] == depth) begin
            m_load[d] = 0; m_run[d] = 1; m_done[d] = 1;
          end
        end
      end
    end
    e.instr = m_ins[d]; e.iv = m_iv[d]; e.ae = m_ae[d];
    e.done = m_done[d]; e.rdy = m_run[d]; e.words = m_words[d];
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
  endtask

  // Monitor: outputs are examined on the falling edge, one record per cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("instr", 0, ins0, e.instr);
      chk("valid", 0, 32'(iv0), 32'(e.iv));
      chk("addr_err", 0, 32'(ae0), 32'(e.ae));
      chk("load_done", 0, 32'(done0), 32'(e.done));
      chk("ready", 0, 32'(rdy0), 32'(e.rdy));
      chk("prog_words", 0, 32'(pw0), 32'(e.words));
`ifdef INSTR_MEM_PARITY_EN
      chk("parity_err", 0, 32'(pe0), 32'd0);
`endif
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("instr", 1, ins1, e.instr);
      chk("valid", 1, 32'(iv1), 32'(e.iv));
      chk("addr_err", 1, 32'(ae1), 32'(e.ae));
      chk("load_done", 1, 32'(done1), 32'(e.done));
      chk("ready", 1, 32'(rdy1), 32'(e.rdy));
      chk("prog_words", 1, 32'(pw1), 32'(e.words));
`ifdef INSTR_MEM_PARITY_EN
      chk("parity_err", 1, 32'(pe1), 32'd0);
`endif
    end
  end

  task automatic step(input bit rn, input bit st, input bit v, input logic [7:0] b,
                      input bit f, input logic [31:0] p);
    exp_t e;
    @(negedge clk); #1;
    rst_n = rn; start = st; valid = v; byte_in = b; fe = f; pc = p;
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
  endtask

  task automatic rnd_fetch(output bit f, output logic [31:0] p);
    f = ($urandom_range(0, 3) != 0);
    p = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
  endtask

  task automatic fetch(input logic [31:0] p); step(1, 0, 0, 8'h00, 1, p); endtask
  task automatic stall(input logic [31:0] p); step(1, 0, 0, 8'h00, 0, p); endtask

  task automatic start_load();
    step(1, 1, 0, 8'h00, 0, 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    bit f; logic [31:0] p;
    while ($urandom_range(0, 3) == 0) begin
      rnd_fetch(f, p); step(1, 0, 0, 8'($urandom), f, p);
    end
    rnd_fetch(f, p); step(1, 0, 1, b, f, p);
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) load_byte(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return (w == HALT) ? 32'h0 : w;
  endfunction

  initial begin
    bit f; logic [31:0] p;
    rst_n = 0; start = 0; valid = 0; byte_in = 0; fe = 0; pc = 0;
    repeat (3) step(0, 0, 0, 8'h00, 1, 32'd0);
    fetch(0); fetch(0);

    start_load();
    load_word(32'h3C010005); load_word(32'h00220820); load_word(HALT);
    fetch(4); fetch(6); fetch(12); fetch(8); fetch(0);
    stall(8); stall(8); stall(8); fetch(8);

    // Five non-halt words: the DEPTH=4 copy stops after four.
    start_load();
    repeat (5) load_word(rand_word());
    fetch(12); fetch(16); fetch(0);
    load_word(HALT);
    fetch(12); fetch(16); fetch(20); fetch(24); fetch(13);

    // Reset in the middle of a load, then a clean reload.
    start_load(); load_byte(8'h12); load_byte(8'h34);
    step(0, 0, 1, 8'h56, 1, 32'd0); step(0, 0, 0, 8'h00, 1, 32'd4);
    fetch(0);
    start_load();
    load_word(32'h2008_0001); load_word(32'hAC08_0000); load_word(HALT);
    fetch(0); fetch(4); fetch(8); fetch(12);

    repeat (60) begin
      if ($urandom_range(0, 14) == 0) step(0, 0, 0, 8'h00, 1, 32'd0);
      start_load();
      repeat ($urandom_range(0, 7)) load_word(rand_word());
      if ($urandom_range(0, 9) < 7) load_word(HALT);
      repeat ($urandom_range(5, 20)) begin
        rnd_fetch(f, p);
        step(1, 0, bit'($urandom_range(0, 1)), 8'($urandom), f, p);
      end
    end

    repeat (2) fetch(0);
    @(negedge clk); @(negedge clk); #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d/%0d records left, expected 0/0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
